mc_ctrl_hs: RTL and testbench

- Parametrised multi-cycle RV32I main controller: the successor to the current fixed-latency controller.
- Adds a memory request/ready handshake with wait states, and a bounded wait timeout.
- Adds an illegal-instruction/timeout trap state and cycle/retired-instruction counters.
- Drives the existing multi-cycle datapath control inputs; instantiated beside the datapath in the top level.

---
 rtl/mc_ctrl_hs_pkg.sv | 89 ++++++++
 rtl/mc_ctrl_hs_if.sv | 41 ++++
 rtl/mc_ctrl_hs_alu_dec.sv | 40 ++++
 rtl/mc_ctrl_hs.sv | 249 ++++++++++++++++++++++++
 tb/tb_mc_ctrl_hs.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_hs_pkg.sv
// Shared state, control-field encodings and opcode constants for mc_ctrl_hs.
// Used by the controller top and by the ALU decoder sub-module.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LUI,
        S_TRAP
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SRL = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_DATA   = 2'b01,
        RES_ALURES = 2'b10,
        RES_IMM    = 2'b11
    } res_src_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } src_a_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } src_b_e;

    // Which funct fields the ALU decoder honours.
    typedef enum logic [1:0] {
        OPC_ADD = 2'b00,
        OPC_R   = 2'b01,
        OPC_I   = 2'b10
    } opclass_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    function automatic imm_src_e imm_sel(input logic [6:0] op);
        imm_src_e sel;
        sel = IMM_I;
        case (op)
            OP_STORE:  sel = IMM_S;
            OP_BRANCH: sel = IMM_B;
            OP_JAL:    sel = IMM_J;
            OP_LUI:    sel = IMM_U;
            default:   sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mc_ctrl_hs_if.sv
// Controller <-> datapath/memory signal bundle for mc_ctrl_hs.
// master = controller side, slave = datapath/memory side.
interface mc_ctrl_hs_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             memReady;
    logic             memReq;
    logic             adrSrc;
    logic             IRWrite;
    logic             memWrite;
    logic [1:0]       resultSrc;
    logic [1:0]       aluSrcA;
    logic [1:0]       aluSrcB;
    logic [2:0]       aluControl;
    logic [2:0]       immSrc;
    logic             regWrite;
    logic             branch;
    logic [2:0]       branchType;
    logic             pcUpdate;
    logic             illegal;
    logic             timeout;
    logic [CNT_W-1:0] cycleCnt;
    logic [CNT_W-1:0] instrCnt;

    modport master (
        input  op, funct3, funct7, memReady,
        output memReq, adrSrc, IRWrite, memWrite, resultSrc, aluSrcA, aluSrcB,
               aluControl, immSrc, regWrite, branch, branchType, pcUpdate,
               illegal, timeout, cycleCnt, instrCnt
    );

    modport slave (
        output op, funct3, funct7, memReady,
        input  memReq, adrSrc, IRWrite, memWrite, resultSrc, aluSrcA, aluSrcB,
               aluControl, immSrc, regWrite, branch, branchType, pcUpdate,
               illegal, timeout, cycleCnt, instrCnt
    );
endinterface

// File: rtl/mc_ctrl_hs_alu_dec.sv
// mc_alu_dec: funct3/funct7 + opclass -> ALU operation and illegal-funct flag.
// Build option RV_MUL_EN enables decoding of the R-type MUL encoding.
module mc_alu_dec
    import mc_pkg::*;
(
    input  opclass_e   opclass_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output alu_op_e    alu_ctrl_o,
    output logic       illegal_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        illegal_o  = 1'b0;
        if (opclass_i != OPC_ADD) begin
            case (funct3_i)
                3'b000:  alu_ctrl_o = (opclass_i == OPC_R && funct7_i[5]) ? ALU_SUB : ALU_ADD;
                3'b111:  alu_ctrl_o = ALU_AND;
                3'b110:  alu_ctrl_o = ALU_OR;
                3'b100:  alu_ctrl_o = ALU_XOR;
                3'b010:  alu_ctrl_o = ALU_SLT;
                3'b101:  alu_ctrl_o = ALU_SRL;
                default: illegal_o  = 1'b1;
            endcase
            if (opclass_i == OPC_R) begin
                if (funct7_i != 7'b0000000 && funct7_i != 7'b0100000) begin
                    illegal_o = 1'b1;
                end
`ifdef RV_MUL_EN
                if (funct7_i == 7'b0000001 && funct3_i == 3'b000) begin
                    alu_ctrl_o = ALU_MUL;
                    illegal_o  = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: rtl/mc_ctrl_hs.sv
// mc_ctrl_hs: multi-cycle RV32I main controller with memory handshake,
// wait timeout, sticky traps and cycle/retired counters. Option: RV_MUL_EN.
//
// state      | meaning
// S_FETCH    | request instruction; load IR and PC+4 on memReady
// S_DECODE   | compute PC+imm (branch target) and dispatch on opcode
// S_MEMADR   | rs1 + imm address for load/store
// S_MEMREAD  | data read, waiting for memReady
// S_MEMWB    | write loaded data to rd
// S_MEMWRITE | data write, memWrite held until memReady
// S_EXECR    | R-type ALU op
// S_EXECI    | I-type ALU op
// S_ALUWB    | write ALUOut to rd
// S_BRANCH   | compare rs1/rs2, conditional PC write
// S_JALR     | rs1 + imm target
// S_JAL      | PC write, old PC + 4 into ALUOut
// S_LUI      | write immExt to rd
// S_TRAP     | illegal instruction or wait timeout; held until reset
module mc_ctrl_hs
    import mc_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 255,
    parameter int WAIT_W   = 8
) (
    input logic          clk,
    input logic          rst,
    mc_ctrl_hs_if.master bus
);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;

    logic               mem_req, adr_src, ir_write, mem_write;
    logic               reg_write, branch, pc_update;
    logic [2:0]         branch_type;
    res_src_e           result_src;
    src_a_e             src_a;
    src_b_e             src_b;
    alu_op_e            alu_ctrl;

    opclass_e           opclass;
    alu_op_e            dec_alu;
    logic               dec_illegal;
    logic               wait_limit;

    always_comb begin
        opclass = OPC_ADD;
        if (bus.op == OP_R) begin
            opclass = OPC_R;
        end else if (bus.op == OP_I) begin
            opclass = OPC_I;
        end
    end

    mc_alu_dec u_alu_dec (
        .opclass_i  (opclass),
        .funct3_i   (bus.funct3),
        .funct7_i   (bus.funct7),
        .alu_ctrl_o (dec_alu),
        .illegal_o  (dec_illegal)
    );

    assign wait_limit = (WAIT_MAX != 0) && (wait_cnt_q == WAIT_W'(WAIT_MAX));

    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        mem_req     = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        branch      = 1'b0;
        pc_update   = 1'b0;
        branch_type = 3'b000;
        result_src  = RES_ALUOUT;
        src_a       = SRCA_PC;
        src_b       = SRCB_RS2;
        alu_ctrl    = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                src_b      = SRCB_FOUR;
                result_src = RES_ALURES;
                if (bus.memReady) begin
                    ir_write  = 1'b1;
                    pc_update = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
                if (dec_illegal) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_MEMADR: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (bus.memReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (bus.memReady) state_d = S_FETCH;
            end
            S_EXECR: begin
                src_a    = SRCA_RS1;
                src_b    = SRCB_RS2;
                alu_ctrl = dec_alu;
                state_d  = S_ALUWB;
            end
            S_EXECI: begin
                src_a    = SRCA_RS1;
                src_b    = SRCB_IMM;
                alu_ctrl = dec_alu;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                src_a       = SRCA_RS1;
                src_b       = SRCB_RS2;
                alu_ctrl    = ALU_SUB;
                result_src  = RES_ALUOUT;
                branch      = 1'b1;
                branch_type = bus.funct3;
                state_d     = S_FETCH;
            end
            S_JALR: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                state_d = S_JAL;
            end
            S_JAL: begin
                src_a      = SRCA_OLDPC;
                src_b      = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_update  = 1'b1;
                state_d    = S_ALUWB;
            end
            S_LUI: begin
                result_src = RES_IMM;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase

        // A ready arriving on the limit cycle completes the access instead.
        if (mem_req && !bus.memReady && wait_limit) begin
            state_d   = S_TRAP;
            timeout_d = 1'b1;
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (mem_req && !bus.memReady && state_d == state_q) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (state_q != S_TRAP) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (state_q != S_FETCH && state_d == S_FETCH) begin
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FETCH;
            wait_cnt_q  <= '0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            illegal_q   <= illegal_d;
            timeout_q   <= timeout_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    // Strobes are held off for as long as reset is asserted.
    assign bus.memReq     = mem_req & rst;
    assign bus.IRWrite    = ir_write & rst;
    assign bus.memWrite   = mem_write & rst;
    assign bus.regWrite   = reg_write & rst;
    assign bus.branch     = branch & rst;
    assign bus.pcUpdate   = pc_update & rst;
    assign bus.adrSrc     = adr_src;
    assign bus.resultSrc  = result_src;
    assign bus.aluSrcA    = src_a;
    assign bus.aluSrcB    = src_b;
    assign bus.aluControl = alu_ctrl;
    assign bus.immSrc     = imm_sel(bus.op);
    assign bus.branchType = branch_type;
    assign bus.illegal    = illegal_q;
    assign bus.timeout    = timeout_q;
    assign bus.cycleCnt   = cycle_cnt_q;
    assign bus.instrCnt   = instr_cnt_q;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Self-checking bench for mc_ctrl_hs: decode vector table, hand-written
// corner sequences, and randomized instructions against a cycle/strobe budget model.
module tb_mc_ctrl_hs;

    localparam int CNT_W    = 32;
    localparam int WAIT_MAX = 4;
    localparam int WAIT_W   = 3;

    localparam logic [6:0] O_LOAD  = 7'b0000011;
    localparam logic [6:0] O_STORE = 7'b0100011;
    localparam logic [6:0] O_R     = 7'b0110011;
    localparam logic [6:0] O_I     = 7'b0010011;
    localparam logic [6:0] O_BR    = 7'b1100011;
    localparam logic [6:0] O_JAL   = 7'b1101111;
    localparam logic [6:0] O_JALR  = 7'b1100111;
    localparam logic [6:0] O_LUI   = 7'b0110111;

`ifdef RV_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    typedef struct {
        int cycles; int rw; int mw; int pcu; int irw; int br;
        bit ill; bit tmo;
    } exp_t;

    typedef struct {
        logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
        int cyc; logic [2:0] imm; logic [2:0] alu; bit ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    int         r_cycles, r_rw, r_mw, r_pcu, r_irw, r_br, r_memadr, r_rw_first;
    logic [2:0] r_alu, r_imm;
    longint     exp_cc, exp_ic;

    always #5 clk = ~clk;

    mc_ctrl_hs_if #(.CNT_W(CNT_W)) bus ();

    mc_ctrl_hs #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX), .WAIT_W(WAIT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        bit ok;
        ok = 1'b0;
        case (op)
            O_LOAD, O_STORE, O_BR, O_JAL, O_JALR, O_LUI: ok = 1'b1;
            O_I: ok = (f3 != 3'd1 && f3 != 3'd3);
            O_R: begin
                if (f3 == 3'd1 || f3 == 3'd3)          ok = 1'b0;
                else if (f7 == 7'h00 || f7 == 7'h20)   ok = 1'b1;
                else if (f7 == 7'h01 && f3 == 3'd0)    ok = MUL_ON;
                else                                   ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] exp_alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        logic [2:0] a;
        case (f3)
            3'd0: a = (op == O_R && f7 == 7'h01) ? 3'd7 : (op == O_R && f7 == 7'h20) ? 3'd1 : 3'd0;
            3'd7: a = 3'd2;
            3'd6: a = 3'd3;
            3'd4: a = 3'd4;
            3'd2: a = 3'd5;
            3'd5: a = 3'd6;
            default: a = 3'd0;
        endcase
        return a;
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] op);
        return (op == O_STORE) ? 3'd1 : (op == O_BR) ? 3'd2 : (op == O_JAL) ? 3'd3 :
               (op == O_LUI) ? 3'd4 : 3'd0;
    endfunction

    // Cycle and strobe budget of one instruction given its memory wait counts.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                   input int w0, input int w1);
        exp_t e;
        e = '{default: 0};
        if (w0 > WAIT_MAX) begin
            e.cycles = WAIT_MAX + 1;
            e.tmo = 1'b1;
            return e;
        end
        e.cycles = w0 + 1;
        e.irw = 1;
        e.pcu = 1;
        if (!is_legal(op, f3, f7)) begin
            e.cycles += 1;
            e.ill = 1'b1;
        end else if (op == O_R || op == O_I) begin
            e.cycles += 3; e.rw = 1;
        end else if (op == O_BR) begin
            e.cycles += 2; e.br = 1;
        end else if (op == O_JAL) begin
            e.cycles += 3; e.pcu += 1; e.rw = 1;
        end else if (op == O_JALR) begin
            e.cycles += 4; e.pcu += 1; e.rw = 1;
        end else if (op == O_LUI) begin
            e.cycles += 2; e.rw = 1;
        end else if (w1 > WAIT_MAX) begin
            e.cycles += 2 + WAIT_MAX + 1;
            e.tmo = 1'b1;
            if (op == O_STORE) e.mw = WAIT_MAX + 1;
        end else if (op == O_LOAD) begin
            e.cycles += w1 + 4; e.rw = 1;
        end else begin
            e.cycles += w1 + 3; e.mw = w1 + 1;
        end
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        bus.memReady = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        exp_cc = 0;
        exp_ic = 0;
    endtask

    // Runs one instruction; memReady answers after w0 (fetch) / w1 (data) idle cycles.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input int w0, input int w1);
        int acc;
        int wcur;
        logic [CNT_W-1:0] ic0;
        bus.op = op; bus.funct3 = f3; bus.funct7 = f7;
        r_cycles = 0; r_rw = 0; r_mw = 0; r_pcu = 0; r_irw = 0; r_br = 0;
        r_memadr = 0; r_rw_first = -1; r_alu = '0;
        acc = 0; wcur = w0; ic0 = bus.instrCnt;
        #1 r_imm = bus.immSrc;
        while (r_cycles < 80) begin
            @(negedge clk);
            bus.memReady = bus.memReq ? (acc == wcur) : 1'($urandom_range(0, 1));
            #1;
            if (bus.regWrite) begin
                r_rw++;
                if (r_rw_first < 0) r_rw_first = r_cycles;
            end
            if (bus.memWrite) r_mw++;
            if (bus.pcUpdate) r_pcu++;
            if (bus.IRWrite)  r_irw++;
            if (bus.branch)   r_br++;
            if (bus.memReq && bus.adrSrc) r_memadr++;
            if (r_cycles == w0 + 2) r_alu = bus.aluControl;
            if (bus.memReq) begin
                if (bus.memReady) begin acc = 0; wcur = w1; end
                else acc++;
            end
            @(posedge clk);
            #1 r_cycles++;
            if (bus.instrCnt != ic0 || bus.illegal || bus.timeout) break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl[17];
        exp_t e;
        logic [6:0] op, f7;
        logic [2:0] f3;
        int w0, w1, sel, strobes;
        bit seen;

        tbl[0]  = '{O_R,    3'd0, 7'h00, 4, 3'd0, 3'd0, 1'b0};
        tbl[1]  = '{O_R,    3'd0, 7'h20, 4, 3'd0, 3'd1, 1'b0};
        tbl[2]  = '{O_R,    3'd7, 7'h00, 4, 3'd0, 3'd2, 1'b0};
        tbl[3]  = '{O_I,    3'd6, 7'h55, 4, 3'd0, 3'd3, 1'b0};
        tbl[4]  = '{O_I,    3'd4, 7'h00, 4, 3'd0, 3'd4, 1'b0};
        tbl[5]  = '{O_R,    3'd2, 7'h00, 4, 3'd0, 3'd5, 1'b0};
        tbl[6]  = '{O_I,    3'd5, 7'h20, 4, 3'd0, 3'd6, 1'b0};
        tbl[7]  = '{O_I,    3'd0, 7'h20, 4, 3'd0, 3'd0, 1'b0};
        tbl[8]  = '{O_R,    3'd1, 7'h00, 2, 3'd0, 3'd0, 1'b1};
        tbl[9]  = '{O_I,    3'd3, 7'h00, 2, 3'd0, 3'd0, 1'b1};
        tbl[10] = '{O_R,    3'd0, 7'h10, 2, 3'd0, 3'd0, 1'b1};
`ifdef RV_MUL_EN
        tbl[11] = '{O_R,    3'd0, 7'h01, 4, 3'd0, 3'd7, 1'b0};
`else
        tbl[11] = '{O_R,    3'd0, 7'h01, 2, 3'd0, 3'd0, 1'b1};
`endif
        tbl[12] = '{O_BR,   3'd1, 7'h00, 3, 3'd2, 3'd1, 1'b0};
        tbl[13] = '{O_JAL,  3'd0, 7'h00, 4, 3'd3, 3'd0, 1'b0};
        tbl[14] = '{O_LUI,  3'd0, 7'h00, 3, 3'd4, 3'd0, 1'b0};
        tbl[15] = '{O_STORE,3'd2, 7'h00, 4, 3'd1, 3'd0, 1'b0};
        tbl[16] = '{7'h7f,  3'd0, 7'h00, 2, 3'd0, 3'd0, 1'b1};

        bus.op = '0; bus.funct3 = '0; bus.funct7 = '0; bus.memReady = 1'b0;

        // Reset state, strobes forced off while reset is held.
        #2 rst = 1'b0;
        #2;
        check("rst memReq", bus.memReq, 0);
        check("rst IRWrite", bus.IRWrite, 0);
        check("rst cycleCnt", bus.cycleCnt, 0);
        check("rst instrCnt", bus.instrCnt, 0);
        check("rst illegal", bus.illegal, 0);
        check("rst timeout", bus.timeout, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check("rst release fetch memReq", bus.memReq, 1);

        // Decode table, memory always ready.
        for (int i = 0; i < 17; i++) begin
            do_reset();
            run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, 0, 0);
            check($sformatf("vec%0d cycles", i), r_cycles, tbl[i].cyc);
            check($sformatf("vec%0d immSrc", i), r_imm, tbl[i].imm);
            check($sformatf("vec%0d aluControl", i), r_alu, tbl[i].alu);
            check($sformatf("vec%0d illegal", i), bus.illegal, tbl[i].ill);
        end

        // add with memReady tied high.
        do_reset();
        run_instr(O_R, 3'd0, 7'h00, 0, 0);
        check("add regWrite cycle", r_rw_first, 3);
        check("add cycles", r_cycles, 4);
        check("add instrCnt", bus.instrCnt, 1);
        check("add cycleCnt", bus.cycleCnt, 4);

        // lw with three wait cycles on the data read.
        do_reset();
        run_instr(O_LOAD, 3'd2, 7'h00, 0, 3);
        check("lw memReq+adrSrc cycles", r_memadr, 4);
        check("lw regWrite count", r_rw, 1);
        check("lw cycles", r_cycles, 8);

        // Fetch never answered.
        do_reset();
        run_instr(O_R, 3'd0, 7'h00, 1000, 0);
        check("fetch timeout cycles", r_cycles, WAIT_MAX + 1);
        check("fetch timeout flag", bus.timeout, 1);
        check("fetch timeout illegal", bus.illegal, 0);
        check("fetch timeout cycleCnt", bus.cycleCnt, WAIT_MAX + 1);
        repeat (4) @(posedge clk);
        #1 check("trap cycleCnt frozen", bus.cycleCnt, WAIT_MAX + 1);
        check("trap memReq", bus.memReq, 0);

        // Unknown opcode, then no strobes while trapped.
        do_reset();
        run_instr(7'h7f, 3'd0, 7'h00, 0, 0);
        check("bad op cycles", r_cycles, 2);
        check("bad op illegal", bus.illegal, 1);
        strobes = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.memReady = 1'b1;
            #1 strobes += int'(bus.memReq) + int'(bus.IRWrite) + int'(bus.pcUpdate) +
                          int'(bus.regWrite) + int'(bus.memWrite) + int'(bus.branch);
        end
        check("trap strobes", strobes, 0);

        // Reset asserted while a store waits in MEMWRITE.
        do_reset();
        bus.op = O_STORE; bus.funct3 = 3'd2; bus.funct7 = 7'h00;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            bus.memReady = bus.memReq && !bus.adrSrc;
            #1 if (bus.memWrite) seen = 1'b1;
        end
        check("sw reaches memWrite", seen, 1);
        @(posedge clk);
        #1 check("sw memWrite held", bus.memWrite, 1);
        rst = 1'b0;
        #1;
        check("mid-sw reset memWrite", bus.memWrite, 0);
        check("mid-sw reset memReq", bus.memReq, 0);
        check("mid-sw reset cycleCnt", bus.cycleCnt, 0);
        check("mid-sw reset instrCnt", bus.instrCnt, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        bus.memReady = 1'b0;
        #1;
        check("post-reset memReq", bus.memReq, 1);
        check("post-reset adrSrc", bus.adrSrc, 0);
        check("post-reset aluSrcB", bus.aluSrcB, 2);

        // Randomized instruction stream.
        do_reset();
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: op = O_LOAD;  1: op = O_STORE; 2, 3: op = O_R;  4: op = O_I;
                5: op = O_BR;    6: op = O_JAL;   7: op = O_JALR; 8: op = O_LUI;
                default: op = 7'($urandom_range(0, 127));
            endcase
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0, 1: f7 = 7'h00;
                2:    f7 = 7'h20;
                3:    f7 = 7'h01;
                default: f7 = 7'($urandom_range(0, 127));
            endcase
            w0 = ($urandom_range(0, 19) == 0) ? WAIT_MAX + 1 : $urandom_range(0, WAIT_MAX);
            w1 = ($urandom_range(0, 19) == 0) ? WAIT_MAX + 1 : $urandom_range(0, WAIT_MAX);
            e = model(op, f3, f7, w0, w1);
            run_instr(op, f3, f7, w0, w1);
            exp_cc += e.cycles;
            if (!e.ill && !e.tmo) exp_ic++;
            check("rnd cycles", r_cycles, e.cycles);
            check("rnd regWrite", r_rw, e.rw);
            check("rnd memWrite", r_mw, e.mw);
            check("rnd pcUpdate", r_pcu, e.pcu);
            check("rnd IRWrite", r_irw, e.irw);
            check("rnd branch", r_br, e.br);
            check("rnd illegal", bus.illegal, e.ill);
            check("rnd timeout", bus.timeout, e.tmo);
            check("rnd instrCnt", bus.instrCnt, exp_ic);
            check("rnd cycleCnt", bus.cycleCnt, exp_cc);
            check("rnd immSrc", r_imm, exp_imm(op));
            if ((op == O_R || op == O_I) && !e.ill && !e.tmo) begin
                check("rnd aluControl", r_alu, exp_alu(op, f3, f7));
            end
            if (e.ill || e.tmo) begin
                repeat (3) @(posedge clk);
                #1 check("rnd trap cycleCnt frozen", bus.cycleCnt, exp_cc);
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
